axi_line_master: RTL
====================

// Module: axi_line_master
// PURPOSE
//   AXI4 initiator that turns single cache-line read/write requests into INCR bursts on AR/R or AW/W/B.
//   Sits between the L1D miss/writeback path and an AXI slave such as the on-chip memory model.
//   One transaction is outstanding at a time; the line is returned or acknowledged on a valid/ready response port.
// PARAMETERS
//   ID_WIDTH        4     AXI ID width; every request uses the ID given on req_id
//   AXI_DATA_WIDTH  512   AXI data bus width in bits, power of 2, >=64
//   LINE_WIDTH      512   cache-line width in bits, integer multiple of AXI_DATA_WIDTH
//   (derived) BEATS = LINE_WIDTH/AXI_DATA_WIDTH, 1..256; SIZE = log2(AXI_DATA_WIDTH/8)
// PORTS
//   clk           in   1                 clock
//   rst_n         in   1                 asynchronous active-low reset
//   req_valid     in   1                 line request valid
//   req_ready     out  1                 high only in IDLE
//   req_we        in   1                 1 = write line, 0 = read line
//   req_addr      in   32                byte address; aligned down to LINE_WIDTH/8
//   req_id        in   ID_WIDTH          AXI ID for this transaction
//   req_wdata     in   LINE_WIDTH        write line; beat k = bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
//   resp_valid    out  1                 transaction complete
//   resp_ready    in   1                 consumer accepts response
//   resp_we       out  1                 echo of req_we
//   resp_err      out  1                 any non-OKAY resp, ID mismatch or rlast error
//   resp_rdata    out  LINE_WIDTH        assembled read line (all zero after a write)
//   m_aw*/m_ar*   out  id/addr32/len8/size3/burst2/valid; in ready    AXI AW and AR channels
//   m_wdata/m_wstrb/m_wlast/m_wvalid out, m_wready in                 AXI W (strb = AXI_DATA_WIDTH/8)
//   m_bid/m_bresp/m_bvalid in, m_bready out                           AXI B
//   m_rid/m_rdata/m_rresp/m_rlast/m_rvalid in, m_rready out           AXI R
// BEHAVIOUR
//   - Reset: state IDLE, beat counter 0, all valid/ready outputs 0 except req_ready=1; line buffer, resp_* and err cleared.
//   - FSM: IDLE -> (req_valid & req_ready) -> AR or AW; AR -(arready)-> R -(last beat)-> RESP;
//     AW -(awready)-> W -(last beat wready)-> B -(bvalid)-> RESP; RESP -(resp_ready)-> IDLE.
//   - Request captured on the handshake cycle into id/we/addr/line registers; inputs ignored afterwards.
//   - AR/AW: addr = req_addr & ~(LINE_WIDTH/8-1), len = BEATS-1, size = SIZE, burst = 2'b01 (INCR).
//     valid rises the cycle after capture and holds with stable payload until ready.
//   - W issued only after AW accepted; wstrb all ones; wvalid held until wready; wlast only on beat BEATS-1.
//   - R: m_rready=1 only in R; each rvalid beat k written to line slice k; counter increments per beat.
//     Completion on beat BEATS-1 regardless of m_rlast; err set if rlast differs from (k==BEATS-1).
//   - B: m_bready=1 only in B; err set if bresp!=0 or bid!=captured id.
//   - err also set if any rresp!=0 or rid!=captured id; err is sticky until return to IDLE.
//   - RESP: resp_valid=1, resp_* stable until resp_ready; req_ready=0 throughout.
//   - Minimum latency read, BEATS=1, zero-wait slave: req handshake T, arvalid T+1, rvalid earliest T+2, resp_valid T+3.
//   - Counter width clog2(BEATS)+1, no wrap within a burst; reset to 0 on entering AR/AW.
//   - Reset mid-transaction: abandon immediately, return to reset values; no further AXI beats driven.
//   - Unexpected rvalid/bvalid outside R/B is not accepted (ready low); no state effect.
// STRUCTURE
//   - Package axi_line_pkg: AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR, state enum typedef.
//   - Single module; beat mux/demux and line buffer inline; no sub-module.
// TESTING (slave = on-chip AXI memory model, READ_DELAY_CYCLE 1 and 4)
//   1. Write 0x1000 line of byte pattern i, then read 0x1000 -> resp_rdata equals pattern, resp_err=0.
//   2. Read req_addr=0x1234, LINE_WIDTH=512 -> m_araddr=0x1200, arlen=0, arsize=6, arburst=1.
//   3. LINE_WIDTH=1024: write then read -> awlen=1, wlast only on 2nd beat, read line matches across both beats.
//   4. Hold resp_ready=0 for 10 cycles -> resp_valid/resp_rdata stable, req_ready=0, no new AR/AW.
//   5. Slave returns rresp=2 on beat 0 -> resp_err=1; next clean read -> resp_err=0.
//   6. Assert rst_n low during R burst -> next cycle all AXI valids/readies 0, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/axi_line_pkg.sv
// rtl/axi_line_pkg.sv - shared AXI encodings and FSM state type for the line master
package axi_line_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5,
      S_RESP = 3'd6
   } state_t;

endpackage

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - single-outstanding cache-line read/write to AXI4 INCR burst initiator
module axi_line_master
   import axi_line_pkg::*;
#(
   parameter int ID_WIDTH       = 4,
   parameter int AXI_DATA_WIDTH = 512,
   parameter int LINE_WIDTH     = 512
) (
   input  logic                        clk,
   input  logic                        rst_n,
   // line request
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic [31:0]                 req_addr,
   input  logic [ID_WIDTH-1:0]         req_id,
   input  logic [LINE_WIDTH-1:0]       req_wdata,
   // line response
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic                        resp_we,
   output logic                        resp_err,
   output logic [LINE_WIDTH-1:0]       resp_rdata,
   // AXI AW
   output logic [ID_WIDTH-1:0]         m_awid,
   output logic [31:0]                 m_awaddr,
   output logic [7:0]                  m_awlen,
   output logic [2:0]                  m_awsize,
   output logic [1:0]                  m_awburst,
   output logic                        m_awvalid,
   input  logic                        m_awready,
   // AXI W
   output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
   output logic                        m_wlast,
   output logic                        m_wvalid,
   input  logic                        m_wready,
   // AXI B
   input  logic [ID_WIDTH-1:0]         m_bid,
   input  logic [1:0]                  m_bresp,
   input  logic                        m_bvalid,
   output logic                        m_bready,
   // AXI AR
   output logic [ID_WIDTH-1:0]         m_arid,
   output logic [31:0]                 m_araddr,
   output logic [7:0]                  m_arlen,
   output logic [2:0]                  m_arsize,
   output logic [1:0]                  m_arburst,
   output logic                        m_arvalid,
   input  logic                        m_arready,
   // AXI R
   input  logic [ID_WIDTH-1:0]         m_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]                  m_rresp,
   input  logic                        m_rlast,
   input  logic                        m_rvalid,
   output logic                        m_rready
);

   localparam int               BEATS     = LINE_WIDTH / AXI_DATA_WIDTH;
   localparam int               CNT_W     = $clog2(BEATS) + 1;
   localparam int               SIZE      = $clog2(AXI_DATA_WIDTH / 8);
   localparam logic [31:0]      LINE_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   state_t                      r_state;
   state_t                      w_next;
   logic [CNT_W-1:0]            r_cnt;
   logic [ID_WIDTH-1:0]         r_id;
   logic                        r_we;
   logic [31:0]                 r_addr;
   logic [LINE_WIDTH-1:0]       r_line;
   logic                        r_err;
   logic                        w_last_beat;
   logic [AXI_DATA_WIDTH-1:0]   w_wdata;

   assign w_last_beat = (r_cnt == LAST_BEAT);

   // State register; reset abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and handshake decode
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = req_we ? S_AW : S_AR;
         end
         S_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) w_next = S_R;
         end
         S_R: begin
            m_rready = 1'b1;
            if (m_rvalid && w_last_beat) w_next = S_RESP;
         end
         S_AW: begin
            m_awvalid = 1'b1;
            if (m_awready) w_next = S_W;
         end
         S_W: begin
            m_wvalid = 1'b1;
            if (m_wready && w_last_beat) w_next = S_B;
         end
         S_B: begin
            m_bready = 1'b1;
            if (m_bvalid) w_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, beat counter, line buffer and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_id   <= '0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_line <= '0;
         r_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_id   <= req_id;
                  r_we   <= req_we;
                  r_addr <= req_addr & LINE_MASK;
                  r_line <= req_we ? req_wdata : '0;
                  r_cnt  <= '0;
                  r_err  <= 1'b0;
               end
            end
            S_R: begin
               if (m_rvalid) begin
                  for (int k = 0; k < BEATS; k++) begin
                     if (r_cnt == CNT_W'(k))
                        r_line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= m_rdata;
                  end
                  if (!w_last_beat) r_cnt <= r_cnt + CNT_W'(1);
                  if ((m_rresp != AXI_RESP_OKAY) || (m_rid != r_id) || (m_rlast != w_last_beat))
                     r_err <= 1'b1;
               end
            end
            S_W: begin
               if (m_wready && !w_last_beat) r_cnt <= r_cnt + CNT_W'(1);
            end
            S_B: begin
               if (m_bvalid && ((m_bresp != AXI_RESP_OKAY) || (m_bid != r_id)))
                  r_err <= 1'b1;
            end
            S_RESP: begin
               if (resp_ready) r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Select the outgoing write beat from the captured line
   always_comb begin
      w_wdata = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (r_cnt == CNT_W'(k)) w_wdata = r_line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
   end

   assign m_arid     = r_id;
   assign m_araddr   = r_addr;
   assign m_arlen    = 8'(BEATS - 1);
   assign m_arsize   = 3'(SIZE);
   assign m_arburst  = AXI_BURST_INCR;

   assign m_awid     = r_id;
   assign m_awaddr   = r_addr;
   assign m_awlen    = 8'(BEATS - 1);
   assign m_awsize   = 3'(SIZE);
   assign m_awburst  = AXI_BURST_INCR;

   assign m_wdata    = w_wdata;
   assign m_wstrb    = '1;
   assign m_wlast    = (r_state == S_W) && w_last_beat;

   assign resp_we    = r_we;
   assign resp_err   = r_err;
   assign resp_rdata = r_we ? '0 : r_line;

endmodule
